// File: rtl/mv_avg_meas_pkg.sv
// Shared types and helpers for the moving-average measurement sequencer.
// State encoding, window-size derivation and counter-width helpers.
package mv_avg_meas_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        WARMUP  = 3'd2,
        MEASURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Averager window length in samples
    function automatic int fifo_size(input int log2_len);
        return 1 << log2_len;
    endfunction

    // Bits needed to hold values 0..max_val (never less than 1)
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mv_avg_meas_stat.sv
// Result tracker: last ch0/ch1 averages, signed ch0 maximum and
// the threshold decision taken on the final accepted average.
module mv_avg_meas_stat
    import mv_avg_meas_pkg::*;
#(
    parameter int DATA_WIDTH0 = 16,
    parameter int DATA_WIDTH1 = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          arm,
    input  logic                          accept,
    input  logic                          decide,
    input  logic signed [DATA_WIDTH0-1:0] in0,
    input  logic signed [DATA_WIDTH1-1:0] in1,
    input  logic signed [DATA_WIDTH0-1:0] thresh,
    output logic signed [DATA_WIDTH0-1:0] last0,
    output logic signed [DATA_WIDTH1-1:0] last1,
    output logic signed [DATA_WIDTH0-1:0] max0,
    output logic                          over_thresh
);

    logic                          first;
    logic signed [DATA_WIDTH0-1:0] next_max;

    // First accepted average loads the max, later ones compete with it
    always_comb begin
        next_max = max0;
        if (first || (in0 > max0)) begin
            next_max = in0;
        end
    end

    // Result registers update only on accepted averages; decision
    // uses the max including the completing average
    always_ff @(posedge clk) begin
        if (rst) begin
            first       <= 1'b0;
            last0       <= '0;
            last1       <= '0;
            max0        <= '0;
            over_thresh <= 1'b0;
        end else if (arm) begin
            first       <= 1'b1;
            over_thresh <= 1'b0;
        end else if (accept) begin
            first <= 1'b0;
            last0 <= in0;
            last1 <= in1;
            max0  <= next_max;
            if (decide) begin
                over_thresh <= (next_max > thresh);
            end
        end
    end

endmodule

// File: rtl/mv_avg_meas_ctrl.sv
// Measurement sequencer for the dual-channel moving averager.
// Optional idle-gap timeout enabled by defining MV_AVG_MEAS_TIMEOUT_EN.
module mv_avg_meas_ctrl
    import mv_avg_meas_pkg::*;
#(
    parameter int DATA_WIDTH0    = 16,
    parameter int DATA_WIDTH1    = 16,
    parameter int LOG2_AVG_LEN   = 5,
    parameter int FLUSH_CYCLES   = 16,
    parameter int MEAS_CNT_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [MEAS_CNT_WIDTH-1:0]     meas_len,
    input  logic signed [DATA_WIDTH0-1:0] thresh0,
    input  logic                          sample_valid,
    output logic                          avg_rstn,
    output logic                          avg_in_valid,
    input  logic signed [DATA_WIDTH0-1:0] avg_out0,
    input  logic signed [DATA_WIDTH1-1:0] avg_out1,
    input  logic                          avg_out_valid,
    output logic                          busy,
    output logic                          result_valid,
    output logic signed [DATA_WIDTH0-1:0] result_last0,
    output logic signed [DATA_WIDTH1-1:0] result_last1,
    output logic signed [DATA_WIDTH0-1:0] result_max0,
    output logic                          over_thresh
`ifdef MV_AVG_MEAS_TIMEOUT_EN
    ,
    output logic                          timeout
`endif
);

    localparam int FIFO_SIZE = fifo_size(LOG2_AVG_LEN);
    localparam int DISC_W    = LOG2_AVG_LEN + 1;
    localparam int FLUSH_W   = cnt_width(FLUSH_CYCLES - 1);

    localparam logic [DISC_W-1:0]  DISC_LAST  = DISC_W'(FIFO_SIZE - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);

`ifdef MV_AVG_MEAS_TIMEOUT_EN
    localparam int GAP_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
`endif

    state_t                        state;
    logic [FLUSH_W-1:0]            flush_cnt;
    logic [DISC_W-1:0]             disc_cnt;
    logic [DISC_W-1:0]             disc_next;
    logic [MEAS_CNT_WIDTH-1:0]     meas_cnt;
    logic [MEAS_CNT_WIDTH-1:0]     meas_len_q;
    logic signed [DATA_WIDTH0-1:0] thresh_q;
    logic                          arm;
    logic                          accept;
    logic                          last_meas;
    logic                          decide;
    logic                          collecting;

`ifdef MV_AVG_MEAS_TIMEOUT_EN
    logic [GAP_W-1:0]              gap_cnt;
    logic                          tmo_hit;
`endif

    // Handshake decode shared by the FSM and the result tracker
    always_comb begin
        collecting = (state == WARMUP) || (state == MEASURE);
        arm        = (state == IDLE) && start;
        accept     = (state == MEASURE) && avg_out_valid && !abort;
        last_meas  = (meas_cnt == meas_len_q - MEAS_CNT_WIDTH'(1));
        decide     = accept && last_meas;
        disc_next  = disc_cnt + DISC_W'(avg_out_valid);
    end

`ifdef MV_AVG_MEAS_TIMEOUT_EN
    // Gap limit reached on a cycle with no averager output
    always_comb begin
        tmo_hit = collecting && !avg_out_valid && (gap_cnt == GAP_LAST);
    end
`endif

    assign avg_in_valid = sample_valid && collecting;
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE) && !abort;

    // Sequencer FSM: flush, warm-up discard, collect, report
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            avg_rstn   <= 1'b0;
            flush_cnt  <= '0;
            disc_cnt   <= '0;
            meas_cnt   <= '0;
            meas_len_q <= '0;
            thresh_q   <= '0;
`ifdef MV_AVG_MEAS_TIMEOUT_EN
            gap_cnt    <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
`ifdef MV_AVG_MEAS_TIMEOUT_EN
            timeout <= 1'b0;
            if (collecting && !avg_out_valid) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end
`endif
            if (abort && (state != IDLE)) begin
                state    <= IDLE;
                avg_rstn <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        avg_rstn <= 1'b1;
                        if (start) begin
                            meas_len_q <= (meas_len == '0) ?
                                          MEAS_CNT_WIDTH'(1) : meas_len;
                            thresh_q   <= thresh0;
                            flush_cnt  <= FLUSH_LOAD;
                            disc_cnt   <= '0;
                            meas_cnt   <= '0;
                            avg_rstn   <= 1'b0;
                            state      <= FLUSH;
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt == '0) begin
                            avg_rstn <= 1'b1;
                            state    <= WARMUP;
                        end else begin
                            flush_cnt <= flush_cnt - FLUSH_W'(1);
                        end
                    end
                    WARMUP: begin
`ifdef MV_AVG_MEAS_TIMEOUT_EN
                        if (tmo_hit) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                        end else
`endif
                        begin
                            disc_cnt <= disc_next;
                            if (disc_next == DISC_LAST) begin
                                state <= MEASURE;
                            end
                        end
                    end
                    MEASURE: begin
                        if (accept) begin
                            meas_cnt <= meas_cnt + MEAS_CNT_WIDTH'(1);
                            if (last_meas) begin
                                state <= DONE;
                            end
                        end
`ifdef MV_AVG_MEAS_TIMEOUT_EN
                        else if (tmo_hit) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                        end
`endif
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    mv_avg_meas_stat #(
        .DATA_WIDTH0 (DATA_WIDTH0),
        .DATA_WIDTH1 (DATA_WIDTH1)
    ) u_stat (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .accept      (accept),
        .decide      (decide),
        .in0         (avg_out0),
        .in1         (avg_out1),
        .thresh      (thresh_q),
        .last0       (result_last0),
        .last1       (result_last1),
        .max0        (result_max0),
        .over_thresh (over_thresh)
    );

endmodule

// File: tb/tb_mv_avg_meas_ctrl.sv
// Directed bench for mv_avg_meas_ctrl with a result scoreboard.
// Define MV_AVG_MEAS_TIMEOUT_EN to also exercise the idle-gap timeout.
module tb_mv_avg_meas_ctrl;

    localparam int DW0   = 16;
    localparam int DW1   = 16;
    localparam int L2    = 5;
    localparam int FLUSH = 16;
    localparam int MW    = 16;
    localparam int TMO   = 64;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  abort;
    logic [MW-1:0]         meas_len;
    logic signed [DW0-1:0] thresh0;
    logic                  sample_valid;
    logic                  avg_rstn;
    logic                  avg_in_valid;
    logic signed [DW0-1:0] avg_out0;
    logic signed [DW1-1:0] avg_out1;
    logic                  avg_out_valid;
    logic                  busy;
    logic                  result_valid;
    logic signed [DW0-1:0] result_last0;
    logic signed [DW1-1:0] result_last1;
    logic signed [DW0-1:0] result_max0;
    logic                  over_thresh;
`ifdef MV_AVG_MEAS_TIMEOUT_EN
    logic                  timeout;
`endif

    typedef struct {
        logic signed [15:0] last0;
        logic signed [15:0] last1;
        logic signed [15:0] max0;
        logic               over;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   nchk = 0;
    int   nerr = 0;
    int   nres = 0;
    int   low;

    always #5 clk = ~clk;

    mv_avg_meas_ctrl #(
        .DATA_WIDTH0    (DW0),
        .DATA_WIDTH1    (DW1),
        .LOG2_AVG_LEN   (L2),
        .FLUSH_CYCLES   (FLUSH),
        .MEAS_CNT_WIDTH (MW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .meas_len      (meas_len),
        .thresh0       (thresh0),
        .sample_valid  (sample_valid),
        .avg_rstn      (avg_rstn),
        .avg_in_valid  (avg_in_valid),
        .avg_out0      (avg_out0),
        .avg_out1      (avg_out1),
        .avg_out_valid (avg_out_valid),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_last0  (result_last0),
        .result_last1  (result_last1),
        .result_max0   (result_max0),
        .over_thresh   (over_thresh)
`ifdef MV_AVG_MEAS_TIMEOUT_EN
        ,
        .timeout       (timeout)
`endif
    );

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest expectation
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            nres++;
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                check("res_last0", result_last0, e.last0);
                check("res_last1", result_last1, e.last1);
                check("res_max0", result_max0, e.max0);
                check("res_over", over_thresh, e.over);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic signed [15:0] v0,
                        input logic signed [15:0] v1);
        avg_out0      = v0;
        avg_out1      = v1;
        avg_out_valid = 1'b1;
        tick();
        avg_out_valid = 1'b0;
    endtask

    task automatic discard(input int n);
        for (int i = 0; i < n; i++) feed(16'sd999, -16'sd999);
    endtask

    task automatic go(input int len, input int th);
        meas_len = MW'(len);
        thresh0  = DW0'(th);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_flush(output int n);
        n = 0;
        for (int i = 0; i < 100 && avg_rstn !== 1'b1; i++) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_result(input string tag);
        int n0;
        int k;
        n0 = nres;
        k  = 0;
        while (nres == n0 && k < 40) begin
            tick();
            k++;
        end
        check({tag, "_seen"}, nres - n0, 1);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        sample_valid  = 1'b1;
        avg_out_valid = 1'b0;
        meas_len      = '0;
        thresh0       = '0;
        avg_out0      = '0;
        avg_out1      = '0;
        repeat (3) tick();
        check("rst_avg_rstn", avg_rstn, 0);
        check("rst_busy", busy, 0);
        check("rst_rv", result_valid, 0);
        check("rst_in_valid", avg_in_valid, 0);
        check("rst_last0", result_last0, 0);
        check("rst_last1", result_last1, 0);
        check("rst_max0", result_max0, 0);
        check("rst_over", over_thresh, 0);
        rst = 1'b0;
        tick();
        check("rel_avg_rstn", avg_rstn, 1);
        check("idle_in_valid", avg_in_valid, 0);

        // Basic four-average measurement
        go(4, 100);
        check("a_busy", busy, 1);
        check("flush_in_valid", avg_in_valid, 0);
        wait_flush(low);
        check("flush_len", low, FLUSH);
        check("warm_in_valid", avg_in_valid, 1);
        discard(31);
        sb.push_back(exp_t'{16'sd70, 16'sd4, 16'sd120, 1'b1});
        feed(16'sd50, 16'sd1);
        feed(16'sd50, 16'sd2);
        feed(16'sd120, 16'sd3);
        feed(16'sd70, 16'sd4);
        wait_result("a");
        check("a_idle_busy", busy, 0);
        check("a_idle_in_valid", avg_in_valid, 0);

        // meas_len 0 behaves as 1; start in MEASURE ignored
        go(0, 0);
        wait_flush(low);
        discard(31);
        meas_len = MW'(5);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("b_start_busy", busy, 1);
        check("b_start_rstn", avg_rstn, 1);
        sb.push_back(exp_t'{-16'sd7, 16'sd9, -16'sd7, 1'b0});
        feed(-16'sd7, 16'sd9);
        wait_result("b");
        feed(16'sd500, 16'sd500);
        tick();
        check("b_idle_ignore", result_last0, -7);

        // Abort on the 10th warm-up output
        go(4, 0);
        wait_flush(low);
        discard(9);
        abort = 1'b1;
        feed(16'sd999, -16'sd999);
        abort = 1'b0;
        check("c_busy", busy, 0);
        check("c_in_valid", avg_in_valid, 0);
        check("c_rstn", avg_rstn, 1);
        repeat (3) tick();

        // Abort coincident with the completing average
        go(4, 0);
        wait_flush(low);
        discard(31);
        feed(16'sd11, 16'sd1);
        feed(16'sd22, 16'sd2);
        feed(16'sd33, 16'sd3);
        abort = 1'b1;
        feed(16'sd44, 16'sd4);
        abort = 1'b0;
        check("d_busy", busy, 0);
        check("d_last0", result_last0, 33);
        check("d_max0", result_max0, 33);
        repeat (5) tick();

        // Signed threshold: negative values above a negative threshold
        go(2, -50);
        wait_flush(low);
        discard(31);
        sb.push_back(exp_t'{-16'sd40, 16'sd5, -16'sd40, 1'b1});
        feed(-16'sd40, 16'sd5);
        feed(-16'sd40, 16'sd5);
        wait_result("e");

        // Max equal to threshold is not over
        go(3, 100);
        wait_flush(low);
        discard(31);
        sb.push_back(exp_t'{16'sd100, 16'sd7, 16'sd100, 1'b0});
        feed(16'sd100, 16'sd0);
        feed(16'sd20, 16'sd0);
        feed(16'sd100, 16'sd7);
        wait_result("f");

        // Reset in the middle of MEASURE
        go(4, 0);
        wait_flush(low);
        discard(31);
        feed(16'sd1, 16'sd1);
        feed(16'sd2, 16'sd2);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("g_rst_rstn", avg_rstn, 0);
            check("g_rst_busy", busy, 0);
            check("g_rst_rv", result_valid, 0);
        end
        check("g_rst_last0", result_last0, 0);
        check("g_rst_max0", result_max0, 0);
        rst = 1'b0;
        tick();
        check("g_rel_rstn", avg_rstn, 1);
        check("g_rel_rv", result_valid, 0);

`ifdef MV_AVG_MEAS_TIMEOUT_EN
        // Averager outputs stop during MEASURE
        go(4, 0);
        wait_flush(low);
        discard(31);
        feed(16'sd5, 16'sd5);
        sample_valid = 1'b0;
        low = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (timeout === 1'b1) begin
                low = i;
                break;
            end
        end
        check("h_timeout_gap", low, TMO);
        check("h_busy", busy, 0);
        tick();
        check("h_pulse", timeout, 0);
        sample_valid = 1'b1;
`endif

        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
